// File: rtl/core_pipe_interlock_pkg.sv
// Shared constants and the outstanding-counter step selection for the s2 interlock scoreboard.
package core_pipe_interlock_pkg;

  localparam int DEF_NREGS     = 32;
  localparam int DEF_RA_W      = 5;
  localparam int DEF_MAX_OUT   = 2;
  localparam int DEF_WB_BYPASS = 1;
  localparam int OUT_CNT_W     = 3;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC
  } cntOp_e;

  // An issue and a writeback in the same cycle cancel; the count never wraps below zero.
  function automatic cntOp_e cntOpSel(input logic inc, input logic dec, input logic isZero);
    if (inc && !dec) return CNT_INC;
    if (dec && !inc && !isZero) return CNT_DEC;
    return CNT_HOLD;
  endfunction

endpackage

// File: rtl/core_pipe_interlock.sv
// Scoreboard beside decode: tracks late-result destinations and stalls s2 on RAW/WAW
// hazards or when too many long-latency ops are outstanding.
module core_pipe_interlock
  import core_pipe_interlock_pkg::*;
#(
  parameter int NREGS     = DEF_NREGS,
  parameter int RA_W      = DEF_RA_W,
  parameter int MAX_OUT   = DEF_MAX_OUT,
  parameter int WB_BYPASS = DEF_WB_BYPASS
) (
  input  logic                 g_clk,
  input  logic                 g_reset,
  input  logic                 s2_valid,
  input  logic                 s3_ready,
  input  logic                 s2_flush,
  input  logic [RA_W-1:0]      s2_rs1_addr,
  input  logic                 s2_rs1_ren,
  input  logic [RA_W-1:0]      s2_rs2_addr,
  input  logic                 s2_rs2_ren,
  input  logic [RA_W-1:0]      s2_rd,
  input  logic                 s2_rd_wen,
  input  logic                 s2_long,
  input  logic                 wb_valid,
  input  logic [RA_W-1:0]      wb_rd,
  output logic                 s2_stall,
  output logic                 s2_issue,
  output logic [NREGS-1:0]     pend_q,
  output logic [OUT_CNT_W-1:0] out_cnt,
  output logic                 sb_err
);

  localparam logic [OUT_CNT_W-1:0] MAX_OUT_C = OUT_CNT_W'(MAX_OUT);

  logic [NREGS-1:0]     r_pend;
  logic [OUT_CNT_W-1:0] r_cnt;
  logic                 r_err;

  logic [NREGS-1:0] w_wbHit;
  logic [NREGS-1:0] w_pendEff;
  logic [NREGS-1:0] w_pendNext;
  logic             w_raw;
  logic             w_waw;
  logic             w_full;
  logic             w_stall;
  logic             w_issue;
  logic             w_setPend;
  logic             w_errNow;
  cntOp_e           w_cntOp;

  // A writeback landing this cycle can release the hazard it was holding.
  always_comb begin
    w_wbHit = '0;
    if (wb_valid) w_wbHit[wb_rd] = 1'b1;
    w_pendEff = r_pend;
    if (WB_BYPASS != 0) w_pendEff = w_pendEff & ~w_wbHit;
    w_pendEff[0] = 1'b0;
  end

  always_comb begin
    w_raw   = (s2_rs1_ren && w_pendEff[s2_rs1_addr]) ||
              (s2_rs2_ren && w_pendEff[s2_rs2_addr]);
    w_waw   = s2_rd_wen && w_pendEff[s2_rd];
    w_full  = s2_long && (r_cnt == MAX_OUT_C) && !wb_valid;
    w_stall = s2_valid && (w_raw || w_waw || w_full);
    w_issue = s2_valid && s3_ready && !w_stall && !s2_flush;
  end

  // Set is applied after clear so a re-issue to the same register keeps it pending.
  always_comb begin
    w_setPend  = w_issue && s2_long && s2_rd_wen && (s2_rd != '0);
    w_pendNext = r_pend;
    if (wb_valid && (wb_rd != '0)) w_pendNext[wb_rd] = 1'b0;
    if (w_setPend) w_pendNext[s2_rd] = 1'b1;
    w_errNow = wb_valid && ((r_cnt == '0) || ((wb_rd != '0) && !r_pend[wb_rd]));
    w_cntOp  = cntOpSel(w_issue && s2_long, wb_valid, r_cnt == '0);
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_pend <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_pend <= w_pendNext;
      r_err  <= r_err | w_errNow;
      case (w_cntOp)
        CNT_INC: r_cnt <= r_cnt + 1'b1;
        CNT_DEC: r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign s2_stall = w_stall;
  assign s2_issue = w_issue;
  assign pend_q   = r_pend;
  assign out_cnt  = r_cnt;
  assign sb_err   = r_err;

endmodule

// File: tb/tb_core_pipe_interlock.sv
// Directed vector table, a reset-while-busy sequence, and randomized traffic against a rule-level scoreboard model.
module tb_core_pipe_interlock;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        s2_valid, s3_ready, s2_flush;
  logic [4:0]  s2_rs1_addr, s2_rs2_addr, s2_rd, wb_rd;
  logic        s2_rs1_ren, s2_rs2_ren, s2_rd_wen, s2_long, wb_valid;
  logic        s2_stall, s2_issue, sb_err;
  logic [31:0] pend_q;
  logic [2:0]  out_cnt;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    logic v, rdy, fl;
    logic [4:0] rs1; logic r1en;
    logic [4:0] rs2; logic r2en;
    logic [4:0] rd;  logic rdwen;
    logic lng, wbv;
    logic [4:0] wbrd;
    logic expStall, expIssue;
    logic [2:0] expCnt;
    logic expErr;
    int chkReg;
    logic expPend;
  } vec_t;

  bit mPend[32];
  int mCnt;
  bit mErr;
  int inflight[$];

  core_pipe_interlock dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .s2_valid(s2_valid), .s3_ready(s3_ready), .s2_flush(s2_flush),
    .s2_rs1_addr(s2_rs1_addr), .s2_rs1_ren(s2_rs1_ren),
    .s2_rs2_addr(s2_rs2_addr), .s2_rs2_ren(s2_rs2_ren),
    .s2_rd(s2_rd), .s2_rd_wen(s2_rd_wen), .s2_long(s2_long),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .s2_stall(s2_stall), .s2_issue(s2_issue),
    .pend_q(pend_q), .out_cnt(out_cnt), .sb_err(sb_err)
  );

  always #5 g_clk = ~g_clk;

  function automatic vec_t mk(int v, int rdy, int fl, int rs1, int r1en, int rs2, int r2en,
                              int rd, int rdwen, int lng, int wbv, int wbrd,
                              int eStall, int eIssue, int eCnt, int eErr, int chk, int ePend);
    vec_t t;
    t.v = 1'(v); t.rdy = 1'(rdy); t.fl = 1'(fl);
    t.rs1 = 5'(rs1); t.r1en = 1'(r1en); t.rs2 = 5'(rs2); t.r2en = 1'(r2en);
    t.rd = 5'(rd); t.rdwen = 1'(rdwen); t.lng = 1'(lng);
    t.wbv = 1'(wbv); t.wbrd = 5'(wbrd);
    t.expStall = 1'(eStall); t.expIssue = 1'(eIssue); t.expCnt = 3'(eCnt);
    t.expErr = 1'(eErr); t.chkReg = chk; t.expPend = 1'(ePend);
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    s2_valid = t.v; s3_ready = t.rdy; s2_flush = t.fl;
    s2_rs1_addr = t.rs1; s2_rs1_ren = t.r1en;
    s2_rs2_addr = t.rs2; s2_rs2_ren = t.r2en;
    s2_rd = t.rd; s2_rd_wen = t.rdwen; s2_long = t.lng;
    wb_valid = t.wbv; wb_rd = t.wbrd;
  endtask

  task automatic idleInputs();
    applyStimulus(mk(0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0));
  endtask

  task automatic runVec(input vec_t t, input int idx);
    @(negedge g_clk);
    applyStimulus(t);
    #1;
    checkOutput($sformatf("vec%0d stall", idx), 32'(s2_stall), 32'(t.expStall));
    checkOutput($sformatf("vec%0d issue", idx), 32'(s2_issue), 32'(t.expIssue));
    @(posedge g_clk);
    #1;
    checkOutput($sformatf("vec%0d out_cnt", idx), 32'(out_cnt), 32'(t.expCnt));
    checkOutput($sformatf("vec%0d sb_err", idx), 32'(sb_err), 32'(t.expErr));
    checkOutput($sformatf("vec%0d pend[%0d]", idx, t.chkReg), 32'(pend_q[t.chkReg]), 32'(t.expPend));
  endtask

  task automatic doReset();
    @(negedge g_clk);
    idleInputs();
    g_reset = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    g_reset = 1'b0;
    checkOutput("reset pend_q", pend_q, 32'h0);
    checkOutput("reset out_cnt", 32'(out_cnt), 32'h0);
    checkOutput("reset sb_err", 32'(sb_err), 32'h0);
    foreach (mPend[i]) mPend[i] = 1'b0;
    mCnt = 0;
    mErr = 1'b0;
    inflight.delete();
  endtask

  // One randomized cycle: the model derives hazards from the pending set and the
  // outstanding count, then applies the clear/set/count/error rules for the edge.
  task automatic randomCycle(input int cyc);
    bit p1, p2, pd, full, expStall, expIssue, bumpRd;
    int r1, r2, rdI, wr;
    logic [31:0] expVec;
    @(negedge g_clk);
    s2_valid = ($urandom_range(0, 3) != 0);
    s3_ready = ($urandom_range(0, 3) != 0);
    s2_flush = ($urandom_range(0, 7) == 0);
    r1 = $urandom_range(0, 7); r2 = $urandom_range(0, 7); rdI = $urandom_range(0, 7);
    s2_rs1_addr = 5'(r1); s2_rs2_addr = 5'(r2); s2_rd = 5'(rdI);
    s2_rs1_ren = 1'($urandom_range(0, 1));
    s2_rs2_ren = 1'($urandom_range(0, 1));
    s2_rd_wen  = ($urandom_range(0, 3) != 0);
    s2_long    = 1'($urandom_range(0, 1));
    wb_valid = 1'b0; wb_rd = '0; wr = 0;
    if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
      int k;
      k = $urandom_range(0, inflight.size() - 1);
      wr = inflight[k];
      inflight.delete(k);
      wb_valid = 1'b1; wb_rd = 5'(wr);
    end else if ($urandom_range(0, 59) == 0) begin
      wr = $urandom_range(0, 7);
      wb_valid = 1'b1; wb_rd = 5'(wr);
    end
    #1;
    p1 = (r1 != 0) && mPend[r1] && !(wb_valid && wr == r1);
    p2 = (r2 != 0) && mPend[r2] && !(wb_valid && wr == r2);
    pd = (rdI != 0) && mPend[rdI] && !(wb_valid && wr == rdI);
    full = s2_long && (mCnt == 2) && !wb_valid;
    expStall = s2_valid && ((s2_rs1_ren && p1) || (s2_rs2_ren && p2) || (s2_rd_wen && pd) || full);
    expIssue = s2_valid && s3_ready && !expStall && !s2_flush;
    checkOutput($sformatf("rnd%0d stall", cyc), 32'(s2_stall), 32'(expStall));
    checkOutput($sformatf("rnd%0d issue", cyc), 32'(s2_issue), 32'(expIssue));

    if (wb_valid && (mCnt == 0 || (wr != 0 && !mPend[wr]))) mErr = 1'b1;
    bumpRd = expIssue && s2_long;
    if (bumpRd && !wb_valid) mCnt++;
    else if (wb_valid && !bumpRd && mCnt > 0) mCnt--;
    if (wb_valid && wr != 0) mPend[wr] = 1'b0;
    if (bumpRd) begin
      if (s2_rd_wen && rdI != 0) begin
        mPend[rdI] = 1'b1;
        inflight.push_back(rdI);
      end else begin
        inflight.push_back(0);
      end
    end

    @(posedge g_clk);
    #1;
    expVec = '0;
    foreach (mPend[i]) expVec[i] = mPend[i];
    checkOutput($sformatf("rnd%0d pend_q", cyc), pend_q, expVec);
    checkOutput($sformatf("rnd%0d out_cnt", cyc), 32'(out_cnt), 32'(mCnt));
    checkOutput($sformatf("rnd%0d sb_err", cyc), 32'(sb_err), 32'(mErr));
  endtask

  initial begin
    vec_t tbl[$];
    g_reset = 1'b1;
    idleInputs();
    repeat (2) @(posedge g_clk);
    doReset();

    //          v r f  rs1 e rs2 e  rd w l  wb wrd  stl iss cnt err chk pend
    tbl.push_back(mk(0,0,0, 0,0, 0,0,  0,0,0, 0,0,  0,0,0,0, 5,0));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  5,1,1, 0,0,  0,1,1,0, 5,1));
    tbl.push_back(mk(1,1,0, 5,1, 0,0, 10,1,0, 0,0,  1,0,1,0, 5,1));
    tbl.push_back(mk(1,1,0, 5,1, 0,0, 10,1,0, 1,5,  0,1,0,0, 5,0));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  6,1,1, 0,0,  0,1,1,0, 6,1));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  7,1,1, 0,0,  0,1,2,0, 7,1));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  8,1,1, 0,0,  1,0,2,0, 8,0));
    tbl.push_back(mk(1,0,0, 0,0, 0,0,  8,1,1, 0,0,  1,0,2,0, 8,0));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  8,1,1, 1,6,  0,1,2,0, 8,1));
    tbl.push_back(mk(0,0,0, 0,0, 0,0,  0,0,0, 0,0,  0,0,2,0, 6,0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0,  0,0,0, 1,7,  0,0,1,0, 7,0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0,  0,0,0, 1,8,  0,0,0,0, 8,0));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  9,1,1, 0,0,  0,1,1,0, 9,1));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  9,1,1, 1,9,  0,1,1,0, 9,1));
    tbl.push_back(mk(0,0,0, 0,0, 0,0,  0,0,0, 1,9,  0,0,0,0, 9,0));
    tbl.push_back(mk(1,1,0, 0,0, 0,0,  0,1,1, 0,0,  0,1,1,0, 0,0));
    tbl.push_back(mk(1,1,0, 0,1, 0,1,  4,1,0, 0,0,  0,1,1,0, 0,0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0,  0,0,0, 1,0,  0,0,0,0, 0,0));
    tbl.push_back(mk(1,1,1, 0,0, 0,0, 11,1,1, 0,0,  0,0,0,0,11,0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0,  0,0,0, 1,3,  0,0,0,1, 3,0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0,  0,0,0, 0,0,  0,0,0,1, 3,0));
    foreach (tbl[i]) runVec(tbl[i], i);

    // Reset while a load is in flight: its late writeback is a protocol error.
    doReset();
    runVec(mk(1,1,0, 0,0, 0,0, 12,1,1, 0,0,  0,1,1,0,12,1), 100);
    doReset();
    runVec(mk(0,0,0, 0,0, 0,0,  0,0,0, 1,12, 0,0,0,1,12,0), 101);

    doReset();
    for (int c = 0; c < 800; c++) begin
      if (c % 97 == 96) doReset();
      randomCycle(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
